execute_muldiv_sequencer: RTL and testbench

Iterative RV32M multiply/divide sequencer attached to the execute stage. It accepts an M-extension operation together with its post-forwarding operands, computes the result one bit per cycle, and drives a stall that freezes fetch, decode and execute until the result is ready. It presents the result for capture into the execute pipeline register in place of the ALU result. Divide-by-zero and signed overflow are resolved in one cycle, without iterating.

---
 rtl/execute_muldiv_sequencer.sv | 164 ++++++++++++++++
 tb/tb_execute_muldiv_sequencer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/execute_muldiv_sequencer.sv
// execute_muldiv_sequencer
//   Iterative RV32M multiply/divide unit for the execute stage. The unit
//   produces one result bit per cycle: shift-add for multiply and restoring
//   division for divide. While the result is pending, it stalls the front of
//   the pipeline. Divide-by-zero and signed overflow finish in one cycle.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   start      execute stage holds a valid M-extension instruction
//   kill       execute instruction is flushed (priority over start)
//   hold       external pipeline stall; keeps DONE (and Result) in place
//   MulDivOpE  funct3 of the M op
//   SrcA/SrcB  forwarded rs1/rs2 values, sampled in the start cycle only
//   stall      combinational freeze request to fetch/decode/execute
//   busy       sequencer is iterating (CALC)
//   valid      Result is available this cycle (DONE)
//   Result     final result, meaningful while valid
module execute_muldiv_sequencer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  kill,
  input  logic                  hold,
  input  logic [2:0]            MulDivOpE,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic                  stall,
  output logic                  busy,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] Result
);

  localparam int DW = DATA_WIDTH;
  localparam int CW = $clog2(DW);
  localparam logic [CW-1:0] LAST   = CW'(DW - 1);
  localparam logic [DW-1:0] ALL1   = '1;
  localparam logic [DW-1:0] MINNEG = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        r_state, w_state_n;
  logic [CW-1:0] r_count;
  logic [2:0]    r_op;
  logic          r_neg;     // final result is negated
  logic [DW-1:0] r_opnd;    // multiplicand (mul) or divisor (div) magnitude
  logic [DW-1:0] r_hi;      // product high half / partial remainder
  logic [DW-1:0] r_lo;      // multiplier -> product low half / dividend -> quotient

  // ---------------- decode of the incoming op (IDLE) ----------------
  logic          w_is_div, w_a_sgn, w_b_sgn, w_sa, w_sb, w_neg;
  logic          w_div0, w_ovf, w_special, w_go;
  logic [DW-1:0] w_abs_a, w_abs_b, w_spec_res;

  always_comb begin
    w_is_div = MulDivOpE[2];
    // mul: A signed unless MULHU; B signed for MUL/MULH. div: signed when funct3[0]==0.
    w_a_sgn  = w_is_div ? ~MulDivOpE[0] : ~(MulDivOpE[1] & MulDivOpE[0]);
    w_b_sgn  = w_is_div ? ~MulDivOpE[0] : ~MulDivOpE[1];
    w_sa     = w_a_sgn & SrcA[DW-1];
    w_sb     = w_b_sgn & SrcB[DW-1];
    w_abs_a  = w_sa ? (~SrcA + 1'b1) : SrcA;
    w_abs_b  = w_sb ? (~SrcB + 1'b1) : SrcB;
    // Remainder follows the dividend; everything else follows the sign XOR.
    w_neg    = (w_is_div & MulDivOpE[1]) ? w_sa : (w_sa ^ w_sb);
    w_div0   = w_is_div & (SrcB == '0);
    w_ovf    = w_is_div & ~MulDivOpE[0] & (SrcA == MINNEG) & (SrcB == ALL1);
    w_special = w_div0 | w_ovf;
    if (w_div0) w_spec_res = MulDivOpE[1] ? SrcA : ALL1;
    else        w_spec_res = MulDivOpE[1] ? '0   : MINNEG;
    w_go     = start & ~kill;
  end

  // ---------------- one iteration (CALC) ----------------
  logic [DW:0]     w_sum, w_shift;
  logic [DW-1:0]   w_diff, w_hi_n, w_lo_n, w_quo, w_rem, w_div_res, w_mul_res, w_final;
  logic            w_ge;
  logic [2*DW-1:0] w_prod, w_prod_s;

  always_comb begin
    // Multiply: conditional add into the high half, then shift {carry,hi,lo} right.
    w_sum   = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_opnd : '0)};
    // Divide: shift next dividend bit into the remainder, and subtract if it fits.
    w_shift = {r_hi, r_lo[DW-1]};
    w_ge    = (w_shift >= {1'b0, r_opnd});
    w_diff  = w_shift[DW-1:0] - r_opnd;   // exact whenever w_ge
    if (r_op[2]) begin
      w_hi_n = w_ge ? w_diff : w_shift[DW-1:0];
      w_lo_n = {r_lo[DW-2:0], w_ge};
    end else begin
      w_hi_n = w_sum[DW:1];
      w_lo_n = {w_sum[0], r_lo[DW-1:1]};
    end
    w_prod    = {w_hi_n, w_lo_n};
    w_prod_s  = r_neg ? (~w_prod + 1'b1) : w_prod;
    w_mul_res = (r_op[1:0] == 2'b00) ? w_prod_s[DW-1:0] : w_prod_s[2*DW-1:DW];
    w_quo     = w_lo_n;
    w_rem     = w_hi_n;
    w_div_res = r_op[1] ? w_rem : w_quo;
    if (r_op[2]) w_final = r_neg ? (~w_div_res + 1'b1) : w_div_res;
    else         w_final = w_mul_res;
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      IDLE: if (w_go) w_state_n = w_special ? DONE : CALC;
      CALC: begin
        if (kill)                  w_state_n = IDLE;
        else if (r_count == LAST)  w_state_n = DONE;
      end
      DONE: if (kill || !hold)     w_state_n = IDLE;
      default:                     w_state_n = IDLE;
    endcase
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
      r_op    <= '0;
      r_neg   <= 1'b0;
      r_opnd  <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      Result  <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_go) begin
          if (w_special) begin
            Result <= w_spec_res;
          end else begin
            r_op    <= MulDivOpE;
            r_neg   <= w_neg;
            r_count <= '0;
            r_hi    <= '0;
            r_opnd  <= w_is_div ? w_abs_b : w_abs_a;
            r_lo    <= w_is_div ? w_abs_a : w_abs_b;
          end
        end
        CALC: if (!kill) begin
          r_hi    <= w_hi_n;
          r_lo    <= w_lo_n;
          r_count <= r_count + CW'(1);
          if (r_count == LAST) Result <= w_final;
        end
        default: ;
      endcase
    end
  end

  assign busy  = (r_state == CALC);
  assign valid = (r_state == DONE);
  assign stall = start & ~kill & (r_state != DONE);

endmodule

// File: tb/tb_execute_muldiv_sequencer.sv
module tb_execute_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0, kill = 1'b0, hold = 1'b0;
  logic [2:0]  MulDivOpE = '0;
  logic [31:0] SrcA = '0, SrcB = '0;
  logic        stall, busy, valid;
  logic [31:0] Result;

  int n_pass = 0;
  int n_tot  = 0;

  execute_muldiv_sequencer #(.DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .kill(kill), .hold(hold),
    .MulDivOpE(MulDivOpE), .SrcA(SrcA), .SrcB(SrcB),
    .stall(stall), .busy(busy), .valid(valid), .Result(Result)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  // One instruction: start held until its DONE cycle. Operands are scrambled
  // after cycle 0, so a late re-sample would corrupt the result.
  task automatic do_vec(input vec_t v);
    int vcyc = -1;
    int bad_stall = 0;
    logic [31:0] got = '0;
    @(posedge clk); #1;
    start = 1'b1; kill = 1'b0; hold = 1'b0;
    MulDivOpE = v.op; SrcA = v.a; SrcB = v.b;
    for (int c = 0; c <= 40; c++) begin
      @(negedge clk);
      if (stall !== (c < v.lat)) bad_stall++;
      if (valid === 1'b1) begin vcyc = c; got = Result; break; end
      @(posedge clk); #1;
      SrcA = ~v.a; SrcB = v.b ^ 32'h5;
    end
    check({v.nm, "_validcyc"}, vcyc, v.lat);
    check({v.nm, "_result"}, got, v.exp);
    check({v.nm, "_stallpat"}, bad_stall, 0);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    int nval, nres;
    logic pv;
    vecs.push_back('{"mul",       3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33});
    vecs.push_back('{"mulhu",     3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33});
    vecs.push_back('{"mulh",      3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33});
    vecs.push_back('{"mulhsu",    3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33});
    vecs.push_back('{"mulh_m1",   3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33});
    vecs.push_back('{"div",       3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33});
    vecs.push_back('{"rem",       3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33});
    vecs.push_back('{"divu",      3'b101, 32'd100,      32'd7,        32'd14,       33});
    vecs.push_back('{"remu",      3'b111, 32'd100,      32'd7,        32'd2,        33});
    vecs.push_back('{"div_by0",   3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1});
    vecs.push_back('{"remu_by0",  3'b111, 32'd5,        32'd0,        32'd5,        1});
    vecs.push_back('{"div_ovf",   3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1});
    vecs.push_back('{"rem_ovf",   3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1});

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_result", Result, 0);
    check("rst_stall", stall, 0);
    reset = 1'b1;

    foreach (vecs[i]) do_vec(vecs[i]);

    // Back-to-back MULs with hold in cycles 33..35.
    nval = 0; nres = 0; pv = 1'b0;
    for (int c = 0; c <= 75; c++) begin
      @(posedge clk); #1;
      hold = (c >= 33 && c <= 35);
      start = (c <= 70);
      MulDivOpE = 3'b000;
      if (c < 37) begin SrcA = 32'd3; SrcB = 32'd5; end
      else        begin SrcA = 32'h1234; SrcB = 32'h10; end
      @(negedge clk);
      if (valid === 1'b1) nval++;
      if (valid === 1'b1 && !pv) nres++;
      pv = valid;
      if (c == 33) check("b2b_res_c33", Result, 32'd15);
      if (c == 36) begin
        check("b2b_valid_c36", valid, 1);
        check("b2b_res_c36", Result, 32'd15);
      end
      if (c == 37) begin
        check("b2b_busy_c37", busy, 0);
        check("b2b_stall_c37", stall, 1);
      end
      if (c == 38) check("b2b_busy_c38", busy, 1);
      if (c == 70) check("b2b_res2", Result, 32'h12340);
    end
    check("b2b_valid_cycles", nval, 5);
    check("b2b_results", nres, 2);
    hold = 1'b0;

    // kill in cycle 10
    @(posedge clk); #1;
    start = 1'b1; MulDivOpE = 3'b101; SrcA = 32'd1000; SrcB = 32'd3;
    repeat (10) begin @(posedge clk); #1; end
    kill = 1'b1;
    @(negedge clk);
    check("kill_stall_c10", stall, 0);
    check("kill_busy_c10", busy, 1);
    @(posedge clk); #1;
    kill = 1'b0; start = 1'b0;
    @(negedge clk);
    check("kill_busy_c11", busy, 0);
    check("kill_valid_c11", valid, 0);
    nval = 0;
    repeat (40) begin @(negedge clk); if (valid === 1'b1) nval++; end
    check("kill_no_valid", nval, 0);

    // async reset during CALC (Result is nonzero from the last MUL)
    @(posedge clk); #1;
    start = 1'b1; MulDivOpE = 3'b000; SrcA = 32'd9; SrcB = 32'd9;
    repeat (5) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_valid", valid, 0);
    check("arst_result", Result, 0);
    start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;

    // resumes normally after reset
    do_vec('{"post_rst_divu", 3'b101, 32'd81, 32'd9, 32'd9, 33});

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
